tdc_meas_ctrl: RTL and testbench

//  Sequences one TDC channel: arms it via its enable input, waits for its done pulse or a timeout,
//  and captures the merged result word into a small result FIFO. Drains it over a valid/ready stream.

---
 rtl/tdc_meas_ctrl_pkg.sv | 31 +++
 rtl/tdc_result_fifo.sv | 84 ++++++++
 rtl/tdc_meas_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_meas_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : tdc_meas_ctrl_pkg
// Purpose: Shared definitions for the TDC measurement controller: FSM state
//          encodings, recovery length, timestamp width and a small helper.
// Ports  : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tdc_meas_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  // Cycles the TDC enable stays low after a measurement so the core can
  // self-reset before the next arm.
  localparam int RECOVER_CYC = 2;

  // Width of the optional epoch timestamp prepended to each result.
  localparam int TS_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_result_fifo.sv
`default_nettype none
// ============================================================================
// Module : tdc_result_fifo
// Purpose: Synchronous result FIFO with extra-bit pointers for full/empty.
//          A pop and a push in the same cycle on a full FIFO are both
//          accepted (pop-before-push). When empty, the read port keeps
//          presenting the most recently popped word.
// Ports  : clk, rst_n      clock, asynchronous active-low reset
//          i_push          write request
//          i_wr_data       write word
//          i_pop           read request (ignored when empty)
//          o_rd_data       head word (last popped word when empty)
//          o_empty         FIFO holds no entries
//          o_wr_ok         the write request is accepted this cycle
// Revision: 1.0 - initial release
// ============================================================================
module tdc_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_wr_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_wr_ok;
  logic [AW-1:0]    w_rd_idx;

  always_comb begin
    w_empty  = (wr_ptr_q == rd_ptr_q);
    w_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    w_pop_ok = i_pop && !w_empty;
    // A pop frees the slot the write lands in, so full+pop still accepts.
    w_wr_ok  = i_push && (!w_full || w_pop_ok);

    // Empty: the slot just behind the read pointer is the last word popped;
    // it cannot have been overwritten, since any write makes the FIFO
    // non-empty. After reset every slot is zero.
    w_rd_idx = w_empty ? (rd_ptr_q[AW-1:0] - AW'(1)) : rd_ptr_q[AW-1:0];

    mem_d = mem_q;
    if (w_wr_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_wr_data;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(w_wr_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(w_pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign o_rd_data = mem_q[w_rd_idx];
  assign o_empty   = w_empty;
  assign o_wr_ok   = w_wr_ok;

endmodule
`default_nettype wire

// File: rtl/tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tdc_meas_ctrl
// Purpose: Sequences one TDC channel (settle, arm, capture or time out,
//          recover), stores results in a small FIFO drained over a
//          valid/ready stream, and keeps sticky overflow/timeout flags and
//          an accepted-result counter. Single-shot or continuous re-arm.
// Config : TDC_TIMESTAMP_EN - when defined, a free-running 16-bit epoch
//          counter is sampled at the done pulse and placed above the TDC
//          word in oData (OUT_W = DATA_W + 16); otherwise OUT_W = DATA_W.
// Ports  : iClk          system clock (shared with the TDC core)
//          iRst          asynchronous active-low reset
//          iStart        arm request, sampled in IDLE only
//          iContinuous   re-arm automatically after each measurement
//          iClrFlags     clears oOverflow and oTimeoutFlag (wins over set)
//          oTdcEnable    TDC enable, high only while ARMED
//          iTdcDone      TDC done pulse, honoured only while ARMED
//          iTdcData      TDC result, valid with iTdcDone
//          oData         FIFO head
//          oValid        FIFO not empty
//          iReady        consumer pop
//          oBusy         controller not idle
//          oOverflow     sticky: a result was dropped on a full FIFO
//          oTimeoutFlag  sticky: a measurement timed out
//          oCount        results written to the FIFO (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module tdc_meas_ctrl
  import tdc_meas_ctrl_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 16,
`ifdef TDC_TIMESTAMP_EN
  localparam int OUT_W      = DATA_W + TS_W
`else
  localparam int OUT_W      = DATA_W
`endif
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iContinuous,
  input  logic              iClrFlags,
  output logic              oTdcEnable,
  input  logic              iTdcDone,
  input  logic [DATA_W-1:0] iTdcData,
  output logic [OUT_W-1:0]  oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oOverflow,
  output logic              oTimeoutFlag,
  output logic [CNT_W-1:0]  oCount
);

  // One timer serves SETTLE, ARMED and RECOVER; it restarts at every
  // state change, so it only has to reach the longest of the three.
  localparam int TMR_W = $clog2(max_int(TIMEOUT_CYC, SETTLE_CYC) + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [OUT_W-1:0]   word_q, word_d;
  logic               ovf_q, ovf_d;
  logic               tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_push;
  logic               w_tmo_set;
  logic               w_wr_ok;
  logic               w_empty;
  logic [OUT_W-1:0]   w_capture_word;

`ifdef TDC_TIMESTAMP_EN
  logic [TS_W-1:0]    epoch_q, epoch_d;

  assign epoch_d        = epoch_q + TS_W'(1);
  assign w_capture_word = {epoch_q, iTdcData};

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      epoch_q <= '0;
    end else begin
      epoch_q <= epoch_d;
    end
  end
`else
  assign w_capture_word = iTdcData;
`endif

  // Next-state, timer and capture register
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + TMR_W'(1);
    word_d    = word_q;
    w_push    = 1'b0;
    w_tmo_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (iStart) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          state_d = ST_ARMED;
          tmr_d   = '0;
        end
      end

      ST_ARMED: begin
        // Done is tested first so it wins over a same-cycle timeout.
        if (iTdcDone) begin
          state_d = ST_CAPTURE;
          tmr_d   = '0;
          word_d  = w_capture_word;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_RECOVER;
          tmr_d     = '0;
          w_tmo_set = 1'b1;
        end
      end

      ST_CAPTURE: begin
        w_push  = 1'b1;
        state_d = ST_RECOVER;
        tmr_d   = '0;
      end

      ST_RECOVER: begin
        if (tmr_q == TMR_W'(RECOVER_CYC - 1)) begin
          tmr_d   = '0;
          state_d = iContinuous ? ST_SETTLE : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Flags and counter; a clear request overrides a same-cycle set.
  always_comb begin
    ovf_d = iClrFlags ? 1'b0 : (ovf_q | (w_push & ~w_wr_ok));
    tmo_d = iClrFlags ? 1'b0 : (tmo_q | w_tmo_set);
    cnt_d = cnt_q + CNT_W'(w_wr_ok);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  tdc_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk       (iClk),
    .rst_n     (iRst),
    .i_push    (w_push),
    .i_wr_data (word_q),
    .i_pop     (iReady),
    .o_rd_data (oData),
    .o_empty   (w_empty),
    .o_wr_ok   (w_wr_ok)
  );

  // Enable and busy decode straight from the state register so an
  // asynchronous reset drops them without waiting for a clock edge.
  assign oTdcEnable   = (state_q == ST_ARMED);
  assign oBusy        = (state_q != ST_IDLE);
  assign oValid       = ~w_empty;
  assign oOverflow    = ovf_q;
  assign oTimeoutFlag = tmo_q;
  assign oCount       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_tdc_meas_ctrl
// Purpose: Self-checking bench for tdc_meas_ctrl (default build). Expected
//          result words are queued when a done pulse is driven and compared
//          as the FIFO presents them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tdc_meas_ctrl;

  localparam int DATA_W      = 24;
  localparam int FIFO_DEPTH  = 8;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 1023;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, cont, clr, done, ready;
  logic              en, valid, busy, ovf, tmo;
  logic [DATA_W-1:0] tdata, odata;
  logic [CNT_W-1:0]  count;

  int                n_checks = 0;
  int                n_pass   = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  tdc_meas_ctrl #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .iClk         (clk),
    .iRst         (rst_n),
    .iStart       (start),
    .iContinuous  (cont),
    .iClrFlags    (clr),
    .oTdcEnable   (en),
    .iTdcDone     (done),
    .iTdcData     (tdata),
    .oData        (odata),
    .oValid       (valid),
    .iReady       (ready),
    .oBusy        (busy),
    .oOverflow    (ovf),
    .oTimeoutFlag (tmo),
    .oCount       (count)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; clr = 1'b0;
    done = 1'b0; ready = 1'b0; tdata = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_en(input int budget, output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 0; i < budget; i++) begin
      if (en === 1'b1) begin ok = 1'b1; break; end
      tick(); n++;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; clr = 1'b0;
    done = 1'b0; ready = 1'b0; tdata = '0;
    repeat (3) tick();
    n_checks++;
    if ({en, valid, busy, ovf, tmo} !== 5'b0) $display("FAIL reset_bits: en/valid/busy/ovf/tmo got %b want 00000", {en, valid, busy, ovf, tmo});
    else n_pass++;
    n_checks++;
    if (count !== '0 || odata !== '0) $display("FAIL reset_words: count got %0d odata got %h want 0/0", count, odata);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || en !== 1'b0) $display("FAIL reset_idle: busy %b en %b want 0 0", busy, en);
    else n_pass++;
  endtask

  task automatic test_single_shot();
    int n; bit ok; logic [DATA_W-1:0] w;
    do_reset();
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || en !== 1'b0) $display("FAIL single_settle: busy %b en %b want 1 0", busy, en);
    else n_pass++;
    wait_en(20, n, ok);
    n_checks++;
    if (!ok || n != SETTLE_CYC) $display("FAIL single_settle_len: armed after %0d (ok=%0d) want %0d", n, ok, SETTLE_CYC);
    else n_pass++;
    repeat (10) tick();
    n_checks++;
    if (en !== 1'b1) $display("FAIL single_armed10: en got %b want 1", en);
    else n_pass++;
    done = 1'b1; tdata = 24'h00A5C3; exp_q.push_back(24'h00A5C3);
    tick();
    done = 1'b0; tdata = '0;
    n_checks++;
    if (valid !== 1'b0 || en !== 1'b0) $display("FAIL single_capture: valid %b en %b want 0 0", valid, en);
    else n_pass++;
    tick();
    n_checks++;
    if (valid !== 1'b1 || odata !== exp_q[0] || count !== 16'd1) $display("FAIL single_result: valid %b data %h count %0d want 1 %h 1", valid, odata, count, exp_q[0]);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_idle: busy got %b want 0", busy);
    else n_pass++;
    ready = 1'b1;
    w = exp_q.pop_front();
    n_checks++;
    if (odata !== w) $display("FAIL single_pop: data got %h want %h", odata, w);
    else n_pass++;
    tick();
    ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || odata !== w) $display("FAIL single_empty_hold: valid %b data %h want 0 %h", valid, odata, w);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n; bit ok;
    do_reset();
    pulse_start();
    wait_en(20, n, ok);
    n = 0;
    while (en === 1'b1 && n < 2000) begin tick(); n++; end
    n_checks++;
    if (!ok || n != TIMEOUT_CYC) $display("FAIL timeout_len: enable high %0d cycles (ok=%0d) want %0d", n, ok, TIMEOUT_CYC);
    else n_pass++;
    n_checks++;
    if (tmo !== 1'b1 || count !== '0 || valid !== 1'b0) $display("FAIL timeout_flags: tmo %b count %0d valid %b want 1 0 0", tmo, count, valid);
    else n_pass++;
    wait_idle(20, ok);
    clr = 1'b1; tick(); clr = 1'b0;
    n_checks++;
    if (!ok || tmo !== 1'b0) $display("FAIL timeout_clear: tmo got %b (idle ok=%0d) want 0", tmo, ok);
    else n_pass++;
    // Clear held across the cycle that would set the flag.
    clr = 1'b1;
    pulse_start();
    wait_en(20, n, ok);
    n = 0;
    while (en === 1'b1 && n < 2000) begin tick(); n++; end
    n_checks++;
    if (tmo !== 1'b0 || n != TIMEOUT_CYC) $display("FAIL timeout_clr_priority: tmo %b after %0d cycles want 0 after %0d", tmo, n, TIMEOUT_CYC);
    else n_pass++;
    clr = 1'b0;
    wait_idle(20, ok);
  endtask

  task automatic test_overflow();
    int n; bit ok; logic [DATA_W-1:0] w;
    do_reset();
    cont = 1'b1;
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      wait_en(30, n, ok);
      n_checks++;
      if (!ok) $display("FAIL overflow_rearm: measurement %0d never armed", k);
      else n_pass++;
      repeat (2) tick();
      done = 1'b1; tdata = DATA_W'(24'h100000 + k);
      if (k <= FIFO_DEPTH) exp_q.push_back(tdata);
      tick();
      done = 1'b0;
      if (k == 9) cont = 1'b0;
    end
    wait_idle(30, ok);
    n_checks++;
    if (!ok || ovf !== 1'b1 || count !== 16'd8 || valid !== 1'b1) $display("FAIL overflow_state: ovf %b count %0d valid %b idle %0d want 1 8 1 1", ovf, count, valid, ok);
    else n_pass++;
    ready = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || odata !== w) $display("FAIL overflow_drain%0d: valid %b data %h want 1 %h", k, valid, odata, w);
      else n_pass++;
      tick();
    end
    ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL overflow_empty: valid got %b want 0", valid);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    int n; bit ok; logic [DATA_W-1:0] w;
    do_reset();
    cont = 1'b1;
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      wait_en(30, n, ok);
      repeat (3) tick();
      if (k == 9) begin
        n_checks++;
        if (!ok || count !== 16'd8) $display("FAIL fullpop_prefill: count %0d armed %0d want 8 1", count, ok);
        else n_pass++;
      end
      done = 1'b1; tdata = DATA_W'(24'h200000 + k);
      exp_q.push_back(tdata);
      tick();
      done = 1'b0;
      if (k == 9) begin
        // CAPTURE cycle with a full FIFO: pop the head here.
        cont = 1'b0;
        w = exp_q.pop_front();
        n_checks++;
        if (valid !== 1'b1 || odata !== w) $display("FAIL fullpop_head: valid %b data %h want 1 %h", valid, odata, w);
        else n_pass++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    end
    wait_idle(30, ok);
    n_checks++;
    if (!ok || ovf !== 1'b0 || count !== 16'd9) $display("FAIL fullpop_state: ovf %b count %0d want 0 9", ovf, count);
    else n_pass++;
    ready = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || odata !== w) $display("FAIL fullpop_drain%0d: valid %b data %h want 1 %h", k, valid, odata, w);
      else n_pass++;
      tick();
    end
    ready = 1'b0;
  endtask

  task automatic test_races();
    int n; bit ok; logic [DATA_W-1:0] w;
    do_reset();
    pulse_start();
    // Done while settling must be ignored.
    done = 1'b1; tdata = 24'hBADBAD;
    tick();
    done = 1'b0;
    wait_en(20, n, ok);
    repeat (TIMEOUT_CYC - 1) tick();
    n_checks++;
    if (!ok || en !== 1'b1) $display("FAIL race_last_armed: en %b (armed %0d) want 1", en, ok);
    else n_pass++;
    done = 1'b1; tdata = 24'h5A5A5A; exp_q.push_back(24'h5A5A5A);
    tick();
    done = 1'b0;
    n_checks++;
    if (tmo !== 1'b0 || en !== 1'b0) $display("FAIL race_done_wins: tmo %b en %b want 0 0", tmo, en);
    else n_pass++;
    wait_idle(20, ok);
    w = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || odata !== w || count !== 16'd1 || tmo !== 1'b0) $display("FAIL race_result: valid %b data %h count %0d tmo %b want 1 %h 1 0", valid, odata, count, tmo, w);
    else n_pass++;
    ready = 1'b1; tick(); ready = 1'b0;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL race_single_word: valid got %b want 0", valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n; bit ok; logic [DATA_W-1:0] w;
    do_reset();
    pulse_start();
    wait_en(20, n, ok);
    repeat (2) tick();
    done = 1'b1; tdata = 24'h0C0FFE;
    tick();
    done = 1'b0;
    wait_idle(20, ok);
    // A timed-out run to leave the timeout flag set.
    pulse_start();
    wait_en(20, n, ok);
    n = 0;
    while (en === 1'b1 && n < 2000) begin tick(); n++; end
    wait_idle(20, ok);
    n_checks++;
    if (valid !== 1'b1 || tmo !== 1'b1 || count !== 16'd1) $display("FAIL areset_pre: valid %b tmo %b count %0d want 1 1 1", valid, tmo, count);
    else n_pass++;
    pulse_start();
    wait_en(20, n, ok);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (en !== 1'b0 || busy !== 1'b0) $display("FAIL areset_enable: en %b busy %b want 0 0", en, busy);
    else n_pass++;
    n_checks++;
    if (valid !== 1'b0 || ovf !== 1'b0 || tmo !== 1'b0 || count !== '0) $display("FAIL areset_clear: valid %b ovf %b tmo %b count %0d want 0 0 0 0", valid, ovf, tmo, count);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_en(20, n, ok);
    repeat (5) tick();
    done = 1'b1; tdata = 24'h123456; exp_q.push_back(24'h123456);
    tick();
    done = 1'b0;
    tick();
    w = exp_q.pop_front();
    n_checks++;
    if (!ok || valid !== 1'b1 || odata !== w || count !== 16'd1) $display("FAIL areset_after: valid %b data %h count %0d want 1 %h 1", valid, odata, count, w);
    else n_pass++;
    wait_idle(20, ok);
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_races();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
